// File: rtl/pipeline_stall_controller.sv
// pipeline_stall_controller
// Central stall/flush sequencer for the 5-stage RV32 pipeline. It merges the
// load-use interlock, the ID-resolved taken-branch flush and multi-cycle
// data-memory waits into PC / pipeline-register enable, bubble and flush
// controls. It also keeps saturating stall/flush cycle counters, and a
// watchdog on memory waits that latches a sticky error.

module pipeline_stall_controller #(
    parameter int CNT_W       = 16,
    parameter int MEM_TIMEOUT = 64
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [6:0]       id_opcode,
    input  logic [4:0]       id_rs1,
    input  logic [4:0]       id_rs2,
    input  logic [4:0]       ex_rd,
    input  logic             ex_mem_read,
    input  logic             branch_taken,
    input  logic             dmem_req,
    input  logic             dmem_ready,
    output logic             pc_enable,
    output logic             if_id_enable,
    output logic             if_id_flush,
    output logic             id_ex_enable,
    output logic             id_ex_bubble,
    output logic             ex_mem_enable,
    output logic             mem_wb_bubble,
    output logic             mem_error,
    output logic [CNT_W-1:0] stall_cycles,
    output logic [CNT_W-1:0] flush_count
);

    localparam logic [6:0] OP_RTYPE  = 7'b0110011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;

    localparam int WAIT_W = $clog2(MEM_TIMEOUT + 1);
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(MEM_TIMEOUT - 1);

    typedef enum logic [1:0] {
        RUN,
        MEM_WAIT,
        ERROR
    } state_t;

    state_t            state;
    logic [WAIT_W-1:0] wait_cnt;

    logic uses_rs1;
    logic uses_rs2;
    logic load_use;
    logic freeze;

    // Decode which source registers the ID instruction reads and detect a
    // dependency on a load that is still in EX.
    always_comb begin
        uses_rs2 = (id_opcode == OP_RTYPE) || (id_opcode == OP_STORE) ||
                   (id_opcode == OP_BRANCH);
        uses_rs1 = uses_rs2 || (id_opcode == OP_LOAD) || (id_opcode == OP_IMM);
        load_use = ex_mem_read && (ex_rd != 5'd0) &&
                   ((uses_rs1 && (ex_rd == id_rs1)) ||
                    (uses_rs2 && (ex_rd == id_rs2)));
    end

    // The pipeline freezes on a fresh unfinished memory access, on every
    // unfinished cycle of an ongoing wait, and permanently once timed out.
    always_comb begin
        freeze = 1'b0;
        case (state)
            RUN:      freeze = dmem_req && !dmem_ready;
            MEM_WAIT: freeze = !dmem_ready;
            ERROR:    freeze = 1'b1;
            default:  freeze = 1'b1;
        endcase
    end

    // Zero-latency control outputs: forced off during reset, full freeze while
    // memory holds the pipe, otherwise run defaults with load-use taking
    // priority over the branch flush so flush and bubble never coincide.
    always_comb begin
        pc_enable     = 1'b0;
        if_id_enable  = 1'b0;
        if_id_flush   = 1'b0;
        id_ex_enable  = 1'b0;
        id_ex_bubble  = 1'b0;
        ex_mem_enable = 1'b0;
        mem_wb_bubble = 1'b0;
        if (reset) begin
            if (freeze) begin
                mem_wb_bubble = 1'b1;
            end else begin
                pc_enable     = 1'b1;
                if_id_enable  = 1'b1;
                id_ex_enable  = 1'b1;
                ex_mem_enable = 1'b1;
                if (load_use) begin
                    pc_enable    = 1'b0;
                    if_id_enable = 1'b0;
                    id_ex_bubble = 1'b1;
                end else if (branch_taken) begin
                    if_id_flush = 1'b1;
                end
            end
        end
    end

    // State machine, memory-wait watchdog, sticky error and saturating
    // performance counters, all cleared together by reset.
    always_ff @(posedge clock) begin
        if (!reset) begin
            state        <= RUN;
            wait_cnt     <= '0;
            mem_error    <= 1'b0;
            stall_cycles <= '0;
            flush_count  <= '0;
        end else begin
            if (!pc_enable && (stall_cycles != '1)) begin
                stall_cycles <= stall_cycles + CNT_W'(1);
            end
            if (if_id_flush && (flush_count != '1)) begin
                flush_count <= flush_count + CNT_W'(1);
            end
            case (state)
                RUN: begin
                    if (dmem_req && !dmem_ready) begin
                        state    <= MEM_WAIT;
                        wait_cnt <= WAIT_W'(1);
                    end
                end
                MEM_WAIT: begin
                    if (dmem_ready) begin
                        state    <= RUN;
                        wait_cnt <= '0;
                    end else if (wait_cnt == WAIT_LAST) begin
                        state     <= ERROR;
                        mem_error <= 1'b1;
                    end else begin
                        wait_cnt <= wait_cnt + WAIT_W'(1);
                    end
                end
                ERROR: begin
                    mem_error <= 1'b1;
                end
                default: begin
                    state <= ERROR;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_pipeline_stall_controller.sv
// tb_pipeline_stall_controller
// Directed vectors drive the stall controller; each vector pushes its
// hand-computed control outputs onto a scoreboard queue and a monitor process
// pops and compares on the falling edge. The monitor keeps a small saturating
// counter model fed from the expected control bits.

module tb_pipeline_stall_controller;

    localparam int CNT_W       = 4;
    localparam int MEM_TIMEOUT = 4;

    // Expected control vector order:
    // {pc_enable, if_id_enable, if_id_flush, id_ex_enable, id_ex_bubble, ex_mem_enable, mem_wb_bubble}
    localparam logic [6:0] C_OFF = 7'b0000000;
    localparam logic [6:0] C_RUN = 7'b1101010;
    localparam logic [6:0] C_LU  = 7'b0001110;
    localparam logic [6:0] C_BR  = 7'b1111010;
    localparam logic [6:0] C_FRZ = 7'b0000001;

    localparam logic [6:0] OP_R  = 7'b0110011;
    localparam logic [6:0] OP_S  = 7'b0100011;
    localparam logic [6:0] OP_B  = 7'b1100011;
    localparam logic [6:0] OP_L  = 7'b0000011;
    localparam logic [6:0] OP_I  = 7'b0010011;
    localparam logic [6:0] OP_J  = 7'b1101111;

    typedef struct {
        logic       rst_n;
        logic [6:0] ctrl;
        logic       merr;
    } exp_t;

    logic             clock;
    logic             reset;
    logic [6:0]       id_opcode;
    logic [4:0]       id_rs1;
    logic [4:0]       id_rs2;
    logic [4:0]       ex_rd;
    logic             ex_mem_read;
    logic             branch_taken;
    logic             dmem_req;
    logic             dmem_ready;
    logic             pc_enable;
    logic             if_id_enable;
    logic             if_id_flush;
    logic             id_ex_enable;
    logic             id_ex_bubble;
    logic             ex_mem_enable;
    logic             mem_wb_bubble;
    logic             mem_error;
    logic [CNT_W-1:0] stall_cycles;
    logic [CNT_W-1:0] flush_count;

    exp_t             sb_q[$];
    int               checks;
    int               errors;
    logic [CNT_W-1:0] model_stall;
    logic [CNT_W-1:0] model_flush;

    pipeline_stall_controller #(
        .CNT_W       (CNT_W),
        .MEM_TIMEOUT (MEM_TIMEOUT)
    ) dut (
        .clock         (clock),
        .reset         (reset),
        .id_opcode     (id_opcode),
        .id_rs1        (id_rs1),
        .id_rs2        (id_rs2),
        .ex_rd         (ex_rd),
        .ex_mem_read   (ex_mem_read),
        .branch_taken  (branch_taken),
        .dmem_req      (dmem_req),
        .dmem_ready    (dmem_ready),
        .pc_enable     (pc_enable),
        .if_id_enable  (if_id_enable),
        .if_id_flush   (if_id_flush),
        .id_ex_enable  (id_ex_enable),
        .id_ex_bubble  (id_ex_bubble),
        .ex_mem_enable (ex_mem_enable),
        .mem_wb_bubble (mem_wb_bubble),
        .mem_error     (mem_error),
        .stall_cycles  (stall_cycles),
        .flush_count   (flush_count)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    // Drive one cycle of inputs just after the rising edge and queue the
    // expected response for the monitor.
    task automatic applyStimulus(
        input logic       rst_n,
        input logic [6:0] op,
        input logic [4:0] rs1,
        input logic [4:0] rs2,
        input logic [4:0] rd,
        input logic       mr,
        input logic       br,
        input logic       req,
        input logic       rdy,
        input logic [6:0] exp_ctrl,
        input logic       exp_merr
    );
        exp_t e;
        @(posedge clock);
        #1;
        reset        = rst_n;
        id_opcode    = op;
        id_rs1       = rs1;
        id_rs2       = rs2;
        ex_rd        = rd;
        ex_mem_read  = mr;
        branch_taken = br;
        dmem_req     = req;
        dmem_ready   = rdy;
        e.rst_n = rst_n;
        e.ctrl  = exp_ctrl;
        e.merr  = exp_merr;
        sb_q.push_back(e);
    endtask

    // Compare one expected entry against the DUT, then advance the counter
    // model by what that cycle should have done at the next edge.
    task automatic checkOutput(input exp_t e);
        logic [6:0] act;
        act = {pc_enable, if_id_enable, if_id_flush, id_ex_enable,
               id_ex_bubble, ex_mem_enable, mem_wb_bubble};
        checks++;
        if (act !== e.ctrl) begin
            errors++;
            $display("[TB] FAIL ctrl t=%0t actual=%b required=%b", $time, act, e.ctrl);
        end
        checks++;
        if (mem_error !== e.merr) begin
            errors++;
            $display("[TB] FAIL mem_error t=%0t actual=%b required=%b", $time, mem_error, e.merr);
        end
        checks++;
        if (stall_cycles !== model_stall) begin
            errors++;
            $display("[TB] FAIL stall_cycles t=%0t actual=%0d required=%0d", $time, stall_cycles, model_stall);
        end
        checks++;
        if (flush_count !== model_flush) begin
            errors++;
            $display("[TB] FAIL flush_count t=%0t actual=%0d required=%0d", $time, flush_count, model_flush);
        end
        if (!e.rst_n) begin
            model_stall = '0;
            model_flush = '0;
        end else begin
            if (!e.ctrl[6] && (model_stall != '1)) model_stall = model_stall + CNT_W'(1);
            if (e.ctrl[4] && (model_flush != '1)) model_flush = model_flush + CNT_W'(1);
        end
    endtask

    // Monitor: pop and check one expectation per falling edge.
    initial begin
        exp_t e;
        forever begin
            @(negedge clock);
            if (sb_q.size() > 0) begin
                e = sb_q.pop_front();
                checkOutput(e);
            end
        end
    end

    initial begin
        int drain;
        checks       = 0;
        errors       = 0;
        model_stall  = '0;
        model_flush  = '0;
        reset        = 1'b0;
        id_opcode    = 7'd0;
        id_rs1       = 5'd0;
        id_rs2       = 5'd0;
        ex_rd        = 5'd0;
        ex_mem_read  = 1'b0;
        branch_taken = 1'b0;
        dmem_req     = 1'b0;
        dmem_ready   = 1'b0;

        // Reset held: outputs forced off, counters cleared.
        applyStimulus(0, 7'd0, 0, 0, 0, 0, 0, 0, 0, C_OFF, 0);
        applyStimulus(0, 7'd0, 0, 0, 0, 0, 0, 0, 0, C_OFF, 0);

        // Idle run.
        for (int i = 0; i < 10; i++)
            applyStimulus(1, 7'd0, 0, 0, 0, 0, 0, 0, 0, C_RUN, 0);

        // Load-use on rs1 of an R-type: exactly one stall cycle.
        applyStimulus(1, OP_R, 5, 1, 5, 1, 0, 0, 0, C_LU, 0);
        applyStimulus(1, OP_R, 5, 1, 5, 0, 0, 0, 0, C_RUN, 0);

        // Register x0 never interlocks; rs2 ignored for I-type and JAL.
        applyStimulus(1, OP_R, 0, 0, 0, 1, 0, 0, 0, C_RUN, 0);
        applyStimulus(1, OP_I, 3, 7, 7, 1, 0, 0, 0, C_RUN, 0);
        applyStimulus(1, OP_S, 3, 7, 7, 1, 0, 0, 0, C_LU, 0);
        applyStimulus(1, OP_L, 7, 2, 7, 1, 0, 0, 0, C_LU, 0);
        applyStimulus(1, OP_J, 7, 7, 7, 1, 0, 0, 0, C_RUN, 0);
        applyStimulus(1, OP_B, 1, 9, 9, 1, 0, 0, 0, C_LU, 0);
        applyStimulus(1, OP_B, 1, 9, 9, 0, 0, 0, 0, C_RUN, 0);

        // Taken branch flushes; load-use masks it, then it is re-evaluated.
        applyStimulus(1, OP_B, 2, 2, 0, 0, 1, 0, 0, C_BR, 0);
        applyStimulus(1, 7'd0, 0, 0, 0, 0, 0, 0, 0, C_RUN, 0);
        applyStimulus(1, OP_B, 4, 4, 4, 1, 1, 0, 0, C_LU, 0);
        applyStimulus(1, OP_B, 4, 4, 4, 0, 1, 0, 0, C_BR, 0);

        // Memory wait of three cycles, then release.
        for (int i = 0; i < 3; i++)
            applyStimulus(1, 7'd0, 0, 0, 0, 0, 0, 1, 0, C_FRZ, 0);
        applyStimulus(1, 7'd0, 0, 0, 0, 0, 0, 1, 1, C_RUN, 0);

        // Same wait with load-use and branch pending: ignored until release.
        for (int i = 0; i < 3; i++)
            applyStimulus(1, OP_R, 5, 5, 5, 1, 1, 1, 0, C_FRZ, 0);
        applyStimulus(1, OP_R, 5, 5, 5, 1, 1, 1, 1, C_LU, 0);
        applyStimulus(1, 7'd0, 0, 0, 0, 0, 0, 0, 0, C_RUN, 0);

        // Reset during a memory wait returns to RUN with counters cleared.
        applyStimulus(1, 7'd0, 0, 0, 0, 0, 0, 1, 0, C_FRZ, 0);
        applyStimulus(1, 7'd0, 0, 0, 0, 0, 0, 1, 0, C_FRZ, 0);
        applyStimulus(0, 7'd0, 0, 0, 0, 0, 0, 1, 0, C_OFF, 0);
        applyStimulus(1, 7'd0, 0, 0, 0, 0, 0, 0, 0, C_RUN, 0);

        // Enough consecutive branches to saturate flush_count.
        for (int i = 0; i < 17; i++)
            applyStimulus(1, OP_B, 3, 3, 0, 0, 1, 0, 0, C_BR, 0);

        // Watchdog: the 4th unfinished edge enters ERROR, which is sticky
        // and keeps stalling until stall_cycles saturates.
        for (int i = 0; i < 4; i++)
            applyStimulus(1, 7'd0, 0, 0, 0, 0, 0, 1, 0, C_FRZ, 0);
        for (int i = 0; i < 8; i++)
            applyStimulus(1, 7'd0, 0, 0, 0, 0, 0, 1, 0, C_FRZ, 1);
        for (int i = 0; i < 10; i++)
            applyStimulus(1, OP_B, 1, 1, 0, 0, 1, 0, 1, C_FRZ, 1);

        // One reset edge recovers from ERROR.
        applyStimulus(0, 7'd0, 0, 0, 0, 0, 0, 0, 1, C_OFF, 1);
        applyStimulus(1, 7'd0, 0, 0, 0, 0, 0, 0, 0, C_RUN, 0);
        applyStimulus(1, OP_B, 6, 6, 0, 0, 1, 0, 0, C_BR, 0);
        applyStimulus(1, 7'd0, 0, 0, 0, 0, 0, 0, 0, C_RUN, 0);

        drain = 0;
        while ((sb_q.size() > 0) && (drain < 20)) begin
            @(posedge clock);
            drain++;
        end
        if (sb_q.size() > 0) begin
            checks++;
            errors++;
            $display("[TB] FAIL drain pending=%0d required=0", sb_q.size());
        end
        @(posedge clock);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
